// File: rtl/uc_pipe_ctrl.sv
// uc_pipe_ctrl: control FSM for the single-cycle datapath; optional retired counter under UC_RETIRED_CNT_EN
module uc_pipe_ctrl
`ifdef UC_RETIRED_CNT_EN
  #(parameter int RCNT_W = 16)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       halted,
  output logic       illegal
`ifdef UC_RETIRED_CNT_EN
  , output logic [RCNT_W-1:0] retired
`endif
);
  typedef enum logic [1:0] {SQUASH, EXEC, HALTED} state_t;
  state_t state, state_nx;
  logic is_alu, is_li, is_j, is_jz, is_jnz, is_nop, is_halt, is_ill, taken;
  assign is_alu  = Opcode[5];
  assign is_li   = Opcode[5:2] == 4'b0100;
  assign is_j    = Opcode == 6'b000000;
  assign is_jz   = Opcode == 6'b000001;
  assign is_jnz  = Opcode == 6'b000010;
  assign is_nop  = Opcode == 6'b000011;
  assign is_halt = Opcode == 6'b001111;
  assign is_ill  = !(is_alu | is_li | is_j | is_jz | is_jnz | is_nop | is_halt);
  assign taken   = is_j | (is_jz & z) | (is_jnz & ~z);
  // state register; reset lands in SQUASH so the stale first fetch is dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SQUASH;
    else state <= state_nx;
  // next state and control outputs; only EXEC decodes the opcode
  always_comb begin
    state_nx = state;
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3 = 1'b0;
    wez = 1'b0;
    Op = 3'b000;
    halted = 1'b0;
    case (state)
      SQUASH: state_nx = EXEC;
      EXEC: begin
        s_inc = ~(taken | is_halt);
        s_inm = is_li;
        we3 = is_alu | is_li;
        wez = is_alu;
        Op = is_alu ? Opcode[4:2] : 3'b000;
        state_nx = is_halt ? HALTED : taken ? SQUASH : EXEC;
      end
      HALTED: begin
        s_inc = 1'b0;
        halted = 1'b1;
      end
      default: state_nx = SQUASH;
    endcase
  end
  // sticky illegal-opcode flag, only from executed instructions
  always_ff @(posedge clk or posedge reset)
    if (reset) illegal <= 1'b0;
    else if (state == EXEC && is_ill) illegal <= 1'b1;
`ifdef UC_RETIRED_CNT_EN
  // count every instruction that completes an EXEC cycle, wrapping naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) retired <= '0;
    else if (state == EXEC) retired <= retired + 1'b1;
`endif
endmodule

// File: doc/uc_pipe_ctrl.md
Name: uc_pipe_ctrl

Overview:
- Control unit that closes the loop with the single-cycle microcontroller datapath.
- Consumes the datapath's 6-bit Opcode and registered zero flag z. Drives the datapath control inputs: s_inc, s_inm, we3, wez and Op.
- Program memory is read synchronously, so each instruction word is valid one cycle after the PC that addresses it. This block squashes the stale word after reset and after every taken jump.
- Also provides a HALT state and a sticky illegal-opcode flag.

Parameters:
- RCNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction bits [15:10] from the datapath.
- z  in  1  registered zero flag from the datapath.
- s_inc  out  1  1 = PC+1, 0 = load jump target instruc[9:0].
- s_inm  out  1  1 = write immediate instruc[11:4] to the register bank, 0 = write the ALU result.
- we3  out  1  register-bank write enable.
- wez  out  1  zero-flag flip-flop load enable.
- Op  out  3  ALU operation select.
- halted  out  1  high while in the HALTED state.
- illegal  out  1  sticky, set on the first illegal opcode executed.
- retired  out  RCNT_W  retired-instruction count (UC_RETIRED_CNT_EN only).

Behaviour:
- Opcode encoding (decided):
  - 1ppp_xx: ALU op. Op=ppp, we3=1, wez=1, s_inm=0, s_inc=1.
  - 0100_xx: LI. we3=1, s_inm=1, wez=0, s_inc=1, Op=000.
  - 000000: J. s_inc=0.
  - 000001: JZ. s_inc = ~z.
  - 000010: JNZ. s_inc = z.
  - 000011: NOP.
  - 001111: HALT. s_inc=0; the assembler encodes its own address in bits [9:0].
  - Any other opcode is illegal and executes as NOP.
- States: SQUASH, EXEC, HALTED. State register uses the asynchronous reset; outputs are combinational from (state, Opcode, z).
- Reset: state=SQUASH, illegal=0, retired=0. Outputs during reset: s_inc=1, s_inm=0, we3=0, wez=0, Op=000, halted=0.
- SQUASH:
  - Outputs s_inc=1, we3=0, wez=0, s_inm=0, Op=000; Opcode is ignored.
  - Always moves to EXEC on the next cycle.
- EXEC:
  - Decode as above.
  - A taken jump (J; JZ with z=1; JNZ with z=0) moves to SQUASH.
  - HALT moves to HALTED.
  - Everything else stays in EXEC.
  - A not-taken JZ/JNZ behaves as NOP, with no squash.
- HALTED:
  - Outputs s_inc=0, we3=0, wez=0, s_inm=0, Op=000, halted=1.
  - Stays in HALTED until reset; Opcode and z are ignored.
- z is sampled combinationally in the EXEC cycle of the jump. An ALU op immediately before JZ updates z at that edge, so the JZ sees the new value.
- illegal is set at the clock edge ending an EXEC cycle with an illegal opcode. It is cleared only by reset and is never set from SQUASH or HALTED.
- Latency: a taken jump costs 2 cycles (jump + squash). All other instructions cost 1 cycle.
- Reset asserted mid-operation, including in HALTED: immediate return to the reset values. The first instruction after release is always squashed.

Optional Feature:
- Macro UC_RETIRED_CNT_EN.
- Defined:
  - retired increments by 1 at each edge that ends an EXEC cycle, whether the instruction is legal or illegal, including HALT and taken/not-taken jumps.
  - The count wraps modulo 2^RCNT_W.
  - It is frozen in SQUASH and HALTED, and reset to 0.
- Undefined: the retired port and the counter logic are absent.

Test Plan:
- Reset, release, Opcode=100000 held -> cycle 0 SQUASH (we3=0, s_inc=1); cycle 1 we3=1, wez=1, Op=000.
- EXEC, Opcode=010000 -> we3=1, s_inm=1, wez=0, s_inc=1; next cycle still EXEC.
- JZ with z=1 -> s_inc=0 that cycle, next cycle SQUASH with we3=0. JZ with z=0 -> s_inc=1, no squash. JNZ mirrored.
- Opcode=001111 -> s_inc=0 that cycle, then halted=1. Apply 10 ALU opcodes -> we3 and wez stay 0. Pulse reset -> halted=0, state SQUASH.
- Opcode=011000 in EXEC -> NOP outputs, illegal=1 after the edge; the same opcode in SQUASH must not set illegal.
- UC_RETIRED_CNT_EN, RCNT_W=4: run 17 EXEC NOPs -> retired=1 (wrap); jump+squash pair -> +1 only.
